// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the dmem MMIO responder: MMIO page offsets, STATUS
// bit layout and a helper that packs the STATUS word.
package dmem_mmio_pkg;

    localparam int unsigned OFF_W      = 4;
    localparam int unsigned STATUS_W   = 12;

    // MMIO word offsets relative to MMIO_BASE
    localparam logic [OFF_W-1:0] OFF_TXDATA = 4'd0;
    localparam logic [OFF_W-1:0] OFF_STATUS = 4'd1;
    localparam logic [OFF_W-1:0] OFF_CYCLES = 4'd2;

    // STATUS register bit positions
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 8;
    localparam int unsigned ST_CNT_W   = 4;

    // Pack the FIFO flags and occupancy into the low bits of the STATUS word
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic                empty,
        input logic                full,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [STATUS_W-1:0] w;
        w                          = '0;
        w[ST_EMPTY]                = empty;
        w[ST_FULL]                 = full;
        w[ST_OVF]                  = ovf;
        w[ST_CNT_LSB +: ST_CNT_W]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Bus bundle between the processor dmem port and the responder, plus the
// TX byte stream.
//   address/data/wren : initiator -> responder, sampled on rising clock
//   q                 : responder -> initiator, registered read data
//   tx_valid/tx_data  : responder -> downstream byte sink
//   tx_ready          : downstream -> responder
interface dmem_mmio_responder_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;

    modport master (
        output address, data, wren, tx_ready,
        input  q, tx_valid, tx_data
    );

    modport slave (
        input  address, data, wren, tx_ready,
        output q, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_byte_fifo.sv
// Byte FIFO with pointer-based storage and a registered head byte.
//   clock, reset       : clock, async active-high reset
//   push, push_data    : enqueue request; accepted when not full or popping
//   pop                : dequeue request; ignored when empty
//   full, empty, count : registered occupancy flags
//   head               : registered byte at the read pointer
module tx_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       head
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic [7:0]       head_n;

    // Next-state: a full FIFO still accepts a push when the head leaves this cycle
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_n = do_pop  ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;
        wr_ptr_n = do_push ? PTR_W'(wr_ptr + 1'b1) : wr_ptr;
        count_n  = CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        head_n   = head;
        // The incoming byte becomes the head when it lands at the next read slot
        if (do_push && (wr_ptr == rd_ptr_n)) begin
            head_n = push_data;
        end else if (count_n != '0) begin
            head_n = mem[rd_ptr_n];
        end
    end

    // Pointers, flags and head register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr_n;
            count  <= count_n;
            empty  <= (count_n == '0);
            full   <= (count_n == CNT_W'(DEPTH));
            head   <= head_n;
        end
    end

    // Storage is not reset; the pointers alone define valid contents
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the processor dmem port: word RAM below
// MMIO_BASE, MMIO page (TXDATA, STATUS, CYCLES) at MMIO_BASE..MMIO_BASE+15.
//   clock, reset : clock, async active-high reset
//   bus (slave)  : address/data/wren in, registered q out,
//                  tx_valid/tx_data out, tx_ready in
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hFF0,
    parameter int unsigned           FIFO_DEPTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    dmem_mmio_responder_if.slave bus
);

    localparam int unsigned RAM_DEPTH = int'(MMIO_BASE);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] q_r;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] cycles;

    logic                  is_mmio;
    logic [OFF_W-1:0]      offset;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [7:0]            fifo_head;

    logic                  ovf_n;
    logic [DATA_WIDTH-1:0] cycles_n;
    logic [DATA_WIDTH-1:0] rdata;

    // Address decode
    assign is_mmio = (bus.address >= MMIO_BASE);
    assign offset  = OFF_W'(bus.address - MMIO_BASE);

    assign fifo_push = bus.wren && is_mmio && (offset == OFF_TXDATA);
    assign fifo_pop  = bus.tx_valid && bus.tx_ready;

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.data[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_head;
    assign bus.q        = q_r;

    // Register next-state and read mux; reads see pre-edge register values
    always_comb begin
        ovf_n    = overflow;
        cycles_n = DATA_WIDTH'(cycles + DATA_WIDTH'(1));
        rdata    = '0;

        // A dropped byte sets overflow; a pop in the same cycle makes room instead
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_n = 1'b1;
        end
        if (bus.wren && is_mmio && (offset == OFF_STATUS) && bus.data[ST_OVF]) begin
            ovf_n = 1'b0;
        end
        if (bus.wren && is_mmio && (offset == OFF_CYCLES)) begin
            cycles_n = bus.data;
        end

        if (!is_mmio) begin
            rdata = ram[bus.address];
        end else begin
            case (offset)
                OFF_STATUS: rdata = DATA_WIDTH'(pack_status(fifo_empty, fifo_full, overflow,
                                                            ST_CNT_W'(fifo_count)));
                OFF_CYCLES: rdata = cycles;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r      <= '0;
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            q_r      <= rdata;
            overflow <= ovf_n;
            cycles   <= cycles_n;
        end
    end

    // RAM write; the read above uses the pre-edge contents, so read-during-write is old data
    always_ff @(posedge clock) begin
        if (bus.wren && !is_mmio) begin
            ram[bus.address] <= bus.data;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    logic clock;
    logic reset;
    int   passed;
    int   total;

    dmem_mmio_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    dmem_mmio_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .MMIO_BASE  (12'hFF0),
        .FIFO_DEPTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.address = 12'h000;
        bus.data    = 32'h0;
        bus.wren    = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.address = a;
        bus.data    = d;
        bus.wren    = 1'b1;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [11:0] a);
        bus.address = a;
        bus.data    = 32'h0;
        bus.wren    = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.tx_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (bus.q !== 32'h0) $display("FAIL reset_q: got %h expected %h", bus.q, 32'h0);
        else passed++;
        total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid);
        else passed++;
        total++;
        if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data);
        else passed++;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_ram();
        wr(12'h010, 32'hDEADBEEF);
        rd(12'h010);
        total++;
        if (bus.q !== 32'hDEADBEEF) $display("FAIL ram_read: got %h expected DEADBEEF", bus.q);
        else passed++;
        // same-cycle write and read returns old contents
        bus.address = 12'h010;
        bus.data    = 32'h12345678;
        bus.wren    = 1'b1;
        cyc();
        total++;
        if (bus.q !== 32'hDEADBEEF) $display("FAIL ram_rdw_old: got %h expected DEADBEEF", bus.q);
        else passed++;
        rd(12'h010);
        total++;
        if (bus.q !== 32'h12345678) $display("FAIL ram_rdw_new: got %h expected 12345678", bus.q);
        else passed++;
        // last RAM word, just below the MMIO page
        wr(12'hFEF, 32'hA5A55A5A);
        rd(12'hFEF);
        total++;
        if (bus.q !== 32'hA5A55A5A) $display("FAIL ram_top_word: got %h expected A5A55A5A", bus.q);
        else passed++;
        idle();
    endtask

    task automatic test_tx_basic();
        bus.tx_ready = 1'b1;
        bus.address  = 12'hFF0;
        bus.data     = 32'h41;
        bus.wren     = 1'b1;
        total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL tx_pre_valid: got %b expected 0", bus.tx_valid);
        else passed++;
        cyc();
        idle();
        total++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41)
            $display("FAIL tx_basic_out: got valid=%b data=%h expected valid=1 data=41",
                     bus.tx_valid, bus.tx_data);
        else passed++;
        cyc();
        total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL tx_basic_drain: got %b expected 0", bus.tx_valid);
        else passed++;
        // reading TXDATA returns 0 and does not push
        bus.tx_ready = 1'b0;
        rd(12'hFF0);
        total++;
        if (bus.q !== 32'h0 || bus.tx_valid !== 1'b0)
            $display("FAIL txdata_read: got q=%h valid=%b expected q=0 valid=0", bus.q, bus.tx_valid);
        else passed++;
        idle();
    endtask

    task automatic test_overflow();
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(12'hFF0, 32'(i));
        rd(12'hFF1);
        total++;
        if (bus.q !== 32'h00000806) $display("FAIL ovf_status: got %h expected 00000806", bus.q);
        else passed++;
        idle();
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i))
                $display("FAIL ovf_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, bus.tx_valid, bus.tx_data, 8'(i));
            else passed++;
            cyc();
        end
        total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL ovf_ninth_absent: got valid=%b expected 0", bus.tx_valid);
        else passed++;
        bus.tx_ready = 1'b0;
        wr(12'hFF1, 32'h4);
        rd(12'hFF1);
        total++;
        if (bus.q !== 32'h00000001) $display("FAIL ovf_clear: got %h expected 00000001", bus.q);
        else passed++;
        idle();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(12'hFF0, 32'(8'h10 + i));
        total++;
        if (bus.tx_data !== 8'h10) $display("FAIL full_head: got %h expected 10", bus.tx_data);
        else passed++;
        bus.tx_ready = 1'b1;
        wr(12'hFF0, 32'hAA);
        bus.tx_ready = 1'b0;
        rd(12'hFF1);
        total++;
        if (bus.q !== 32'h00000802) $display("FAIL full_pushpop_status: got %h expected 00000802", bus.q);
        else passed++;
        idle();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(8'h11 + i) : 8'hAA;
            total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp)
                $display("FAIL full_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, bus.tx_valid, bus.tx_data, exp);
            else passed++;
            cyc();
        end
        total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL full_drain_empty: got %b expected 0", bus.tx_valid);
        else passed++;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_cycles();
        wr(12'hFF2, 32'h00000100);
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'h00000100) $display("FAIL cyc_load: got %h expected 00000100", bus.q);
        else passed++;
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'h00000101) $display("FAIL cyc_incr: got %h expected 00000101", bus.q);
        else passed++;
        wr(12'hFF2, 32'hFFFFFFFF);
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'hFFFFFFFF) $display("FAIL cyc_max: got %h expected FFFFFFFF", bus.q);
        else passed++;
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'h00000000) $display("FAIL cyc_wrap: got %h expected 00000000", bus.q);
        else passed++;
        // unused MMIO offsets read 0 and ignore writes
        wr(12'hFF7, 32'hFFFFFFFF);
        rd(12'hFF7);
        total++;
        if (bus.q !== 32'h0) $display("FAIL mmio_unused: got %h expected 00000000", bus.q);
        else passed++;
        rd(12'hFFF);
        total++;
        if (bus.q !== 32'h0) $display("FAIL mmio_last: got %h expected 00000000", bus.q);
        else passed++;
        rd(12'hFF1);
        total++;
        if (bus.q !== 32'h00000001) $display("FAIL mmio_unused_status: got %h expected 00000001", bus.q);
        else passed++;
        idle();
    endtask

    task automatic test_reset_mid();
        bus.tx_ready = 1'b0;
        wr(12'hFF0, 32'h61);
        wr(12'hFF0, 32'h62);
        wr(12'hFF0, 32'h63);
        rd(12'hFF2);
        total++;
        if (bus.tx_valid !== 1'b1) $display("FAIL rst_mid_pre: got %b expected 1", bus.tx_valid);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.tx_valid !== 1'b0 || bus.q !== 32'h0 || bus.tx_data !== 8'h00)
            $display("FAIL rst_mid_immediate: got valid=%b q=%h data=%h expected 0/0/0",
                     bus.tx_valid, bus.q, bus.tx_data);
        else passed++;
        cyc();
        reset = 1'b0;
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'h0) $display("FAIL rst_cyc0: got %h expected 00000000", bus.q);
        else passed++;
        rd(12'hFF2);
        total++;
        if (bus.q !== 32'h1) $display("FAIL rst_cyc1: got %h expected 00000001", bus.q);
        else passed++;
        rd(12'hFF1);
        total++;
        if (bus.q !== 32'h00000001 || bus.tx_valid !== 1'b0)
            $display("FAIL rst_status: got q=%h valid=%b expected q=00000001 valid=0",
                     bus.q, bus.tx_valid);
        else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.tx_ready = 1'b0;
        idle();
        test_reset();
        test_ram();
        test_tx_basic();
        test_overflow();
        test_full_push_pop();
        test_cycles();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
